sram_stage_sequencer: RTL and testbench
=======================================

Name: sram_stage_sequencer

Overview:
- Parametrised top-level SRAM access sequencer and arbiter for the image decompressor.
- After reset it idles with VGA owning the SRAM, which is the state it returns to after every run.
- A UART start bit triggers capture of the image into SRAM; the capture ends on a receive timeout.
- It then runs up to NUM_STAGES decoder stages (M-blocks) in a programmable order, with stage skipping and a per-stage watchdog, and muxes the SRAM address/data/we_n of the current owner.

Parameters:
NUM_STAGES, 2, number of decoder stage clients; stage 0 runs first
ADDR_W, 18, SRAM word address width
DATA_W, 16, SRAM data width
TIMER_W, 32, width of the UART timer and the stage watchdog counters
UART_TIMEOUT, 50000000, idle cycles with no UART SRAM write that end reception
STAGE_TIMEOUT, 0, maximum cycles per stage; 0 disables the watchdog

Ports:
CLOCK_50_I  in  1  system clock
resetn  in  1  asynchronous active-low reset
uart_rx_i  in  1  raw UART line; low = start bit
uart_addr_i  in  ADDR_W  UART interface SRAM address
uart_wdata_i  in  DATA_W  UART interface write data
uart_we_n_i  in  1  UART interface write enable, active low
vga_addr_i  in  ADDR_W  VGA interface SRAM address
stage_addr_i  in  NUM_STAGES*ADDR_W  stage addresses; stage k occupies slice [k*ADDR_W +: ADDR_W]
stage_wdata_i  in  NUM_STAGES*DATA_W  stage write data, sliced the same way
stage_we_n_i  in  NUM_STAGES  stage write enables, active low
stage_stop_i  in  NUM_STAGES  stage completion indications
stage_enable_i  in  NUM_STAGES  run mask; a stage whose bit is 0 is skipped
sram_addr_o  out  ADDR_W  muxed SRAM address
sram_wdata_o  out  DATA_W  muxed write data
sram_we_n_o  out  1  muxed write enable
stage_start_o  out  NUM_STAGES  one-cycle start pulses
uart_rx_init_o  out  1  UART interface initialise pulse
uart_rx_enable_o  out  1  UART interface enable pulse
vga_enable_o  out  1  VGA owns the SRAM
busy_o  out  1  high in any state except IDLE
active_stage_o  out  $clog2(NUM_STAGES)+1  index of the current stage; all-ones when no stage is running
timeout_err_o  out  1  sticky watchdog error flag

Behaviour:
- Reset and clocking: reset is asynchronous, active-low, on resetn; clock is CLOCK_50_I.
- Reset values:
  - state = IDLE
  - vga_enable_o = 1
  - stage_start_o = 0, uart_rx_init_o = 0, uart_rx_enable_o = 0
  - timeout_err_o = 0, busy_o = 0
  - active_stage_o = all-ones
  - both timers = 0
- Reset mid-operation aborts immediately. sram_we_n_o goes to 1 asynchronously because the mux then selects IDLE.
- States: IDLE, UART_RX, RUN.
- IDLE:
  - vga_enable_o = 1.
  - uart_rx_i == 0 at a clock edge: go to UART_RX, set uart_rx_init_o = 1, clear the UART timer, set vga_enable_o = 0.
- UART_RX:
  - uart_rx_init_o is high only in the first cycle of UART_RX.
  - uart_rx_enable_o is high only in the second cycle of UART_RX.
  - The UART timer increments every cycle and is cleared in any cycle with uart_we_n_i == 0.
  - When the timer == UART_TIMEOUT-1, the timer is cleared and the sequencer advances to the first stage.
- Advance rule:
  - The next stage is the lowest index j > current (j >= 0 when leaving UART_RX) with stage_enable_i[j] == 1, sampled at the decision edge.
  - If such a j exists: enter RUN with idx = j, and stage_start_o[j] = 1 for exactly the first RUN cycle of that stage.
  - If none exists: return to IDLE, set vga_enable_o = 1, active_stage_o = all-ones.
- RUN, stage idx:
  - stage_stop_i[idx] sampled high at a clock edge, including the start cycle, completes the stage and applies the advance rule at that edge.
  - Stop bits of the other stages are ignored.
  - A zero-length stage therefore lasts exactly 1 cycle.
- Watchdog (STAGE_TIMEOUT > 0):
  - The counter is cleared on stage entry and increments every RUN cycle.
  - On reaching STAGE_TIMEOUT-1 without a stop: set timeout_err_o, go to IDLE, run no further stages.
  - timeout_err_o is cleared only by reset or by the next UART start-bit detection.
  - Stop and expiry in the same cycle: the stop wins, so there is no error.
- Mux, combinational from the registered state:
  - UART_RX: uart_* signals.
  - RUN: the slice of stage idx.
  - IDLE: vga_addr_i, wdata = 0, we_n = 1.
- uart_rx_i is ignored outside IDLE; a start bit is never re-detected while busy.

Test Plan:
- Reset at cycle 0 -> vga_enable_o = 1, sram_we_n_o = 1, busy_o = 0, sram_addr_o follows vga_addr_i = 18'h1234.
- UART_TIMEOUT = 100, drive uart_rx_i low, write 4 words via uart_we_n_i -> init/enable pulses in consecutive cycles, SRAM mirrors uart_* signals; stage_start_o[0] fires exactly 100 cycles after the last write.
- NUM_STAGES = 3, enable = 3'b101 -> stage 0 runs; stage_stop_i[0] -> stage_start_o[2] on the next cycle and stage 1 never starts; stop of stage 2 -> IDLE, vga_enable_o = 1.
- stage_stop_i[1] asserted while stage 0 is running -> ignored; the SRAM mux remains on stage 0's slice.
- STAGE_TIMEOUT = 50, stage 0 never stops -> after 50 RUN cycles timeout_err_o = 1, state IDLE, stage_start_o[1] never pulses.
- enable = 0 -> after the UART timeout, direct return to IDLE with no start pulses; resetn deasserted mid-RUN -> all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/sram_stage_sequencer.sv
// -----------------------------------------------------------------------------
// sram_stage_sequencer
//
// Top-level SRAM access sequencer and arbiter for the image decompressor.
//
// After reset the block idles with the VGA reader owning the SRAM. A UART start
// bit (uart_rx_i low) hands the SRAM to the UART receiver, which writes the
// compressed image. Reception ends once UART_TIMEOUT cycles pass without a UART
// write. The decoder stages (M-blocks) then run one at a time, lowest index
// first, skipping any stage whose stage_enable_i bit is clear. A stage ends when
// its own stage_stop_i bit is seen. An optional per-stage watchdog aborts the
// run and raises a sticky error. After the last stage, or an abort, the SRAM
// returns to VGA.
//
// Ports
//   CLOCK_50_I, resetn              clock, asynchronous active-low reset
//   uart_rx_i                       raw UART line, low = start bit
//   uart_addr_i/_wdata_i/_we_n_i    UART receiver SRAM port
//   vga_addr_i                      VGA reader SRAM address
//   stage_addr_i/_wdata_i/_we_n_i   packed SRAM ports of the decoder stages
//   stage_stop_i                    per-stage completion indication
//   stage_enable_i                  per-stage run mask
//   sram_addr_o/_wdata_o/_we_n_o    muxed SRAM port of the current owner
//   stage_start_o                   one-cycle start pulse per stage
//   uart_rx_init_o/_enable_o        UART receiver init / enable pulses
//   vga_enable_o                    VGA owns the SRAM
//   busy_o                          sequencer is not idle
//   active_stage_o                  running stage index, all-ones when none
//   timeout_err_o                   sticky watchdog error
// -----------------------------------------------------------------------------
module sram_stage_sequencer #(
  parameter int NUM_STAGES    = 2,
  parameter int ADDR_W        = 18,
  parameter int DATA_W        = 16,
  parameter int TIMER_W       = 32,
  parameter int UART_TIMEOUT  = 50000000,
  parameter int STAGE_TIMEOUT = 0
) (
  input  logic                         CLOCK_50_I,
  input  logic                         resetn,
  input  logic                         uart_rx_i,
  input  logic [ADDR_W-1:0]            uart_addr_i,
  input  logic [DATA_W-1:0]            uart_wdata_i,
  input  logic                         uart_we_n_i,
  input  logic [ADDR_W-1:0]            vga_addr_i,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_addr_i,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_wdata_i,
  input  logic [NUM_STAGES-1:0]        stage_we_n_i,
  input  logic [NUM_STAGES-1:0]        stage_stop_i,
  input  logic [NUM_STAGES-1:0]        stage_enable_i,
  output logic [ADDR_W-1:0]            sram_addr_o,
  output logic [DATA_W-1:0]            sram_wdata_o,
  output logic                         sram_we_n_o,
  output logic [NUM_STAGES-1:0]        stage_start_o,
  output logic                         uart_rx_init_o,
  output logic                         uart_rx_enable_o,
  output logic                         vga_enable_o,
  output logic                         busy_o,
  output logic [$clog2(NUM_STAGES):0]  active_stage_o,
  output logic                         timeout_err_o
);

  localparam int IDX_W = $clog2(NUM_STAGES) + 1;

  // The extra index bit guarantees NO_STAGE never aliases a real stage.
  localparam logic [IDX_W-1:0]   NO_STAGE   = '1;
  localparam logic [TIMER_W-1:0] UART_LAST  = TIMER_W'(UART_TIMEOUT - 1);
  localparam bit                 WDOG_ON    = (STAGE_TIMEOUT > 0);
  localparam logic [TIMER_W-1:0] STAGE_LAST = TIMER_W'(WDOG_ON ? STAGE_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UART_RX = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [TIMER_W-1:0]      uart_timer_q, uart_timer_d;
  logic [TIMER_W-1:0]      stage_timer_q, stage_timer_d;
  logic [NUM_STAGES-1:0]   start_q, start_d;
  logic                    init_q, init_d;
  logic                    enable_q, enable_d;
  logic                    err_q, err_d;

  // Next-stage search and current-stage decode
  logic                    next_found;
  logic [IDX_W-1:0]        next_idx;
  logic [NUM_STAGES-1:0]   next_onehot;
  logic                    cur_stop;
  logic                    do_advance;

  // Lowest enabled stage above the current one; when leaving reception every
  // stage qualifies. The descending loop leaves the lowest match in place.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    next_found  = 1'b0;
    next_idx    = NO_STAGE;
    next_onehot = '0;
    cur_stop    = 1'b0;
    for (int j = NUM_STAGES - 1; j >= 0; j--) begin
      if (stage_enable_i[j] && (state_q == UART_RX || j > int'(idx_q))) begin
        next_found     = 1'b1;
        next_idx       = IDX_W'(j);
        next_onehot    = '0;
        next_onehot[j] = 1'b1;
      end
    end
    // Only the running stage's stop bit matters; the others are ignored.
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_stop = stage_stop_i[k];
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    uart_timer_d  = uart_timer_q;
    stage_timer_d = stage_timer_q;
    start_d       = '0;
    init_d        = 1'b0;
    enable_d      = 1'b0;
    err_d         = err_q;
    do_advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!uart_rx_i) begin
          state_d      = UART_RX;
          init_d       = 1'b1;
          uart_timer_d = '0;
          err_d        = 1'b0;
        end
      end

      UART_RX: begin
        // Enable follows init by one cycle, i.e. the second cycle of reception.
        enable_d = init_q;
        if (!uart_we_n_i) begin
          // Any write restarts the idle timeout, even on the final count.
          uart_timer_d = '0;
        end else if (uart_timer_q == UART_LAST) begin
          uart_timer_d = '0;
          do_advance   = 1'b1;
        end else begin
          uart_timer_d = uart_timer_q + 1'b1;
        end
      end

      RUN: begin
        // A stop in the same cycle as watchdog expiry wins over the error.
        if (cur_stop) begin
          do_advance = 1'b1;
        end else if (WDOG_ON && stage_timer_q == STAGE_LAST) begin
          err_d         = 1'b1;
          state_d       = IDLE;
          idx_d         = NO_STAGE;
          stage_timer_d = '0;
        end else if (WDOG_ON) begin
          stage_timer_d = stage_timer_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        idx_d   = NO_STAGE;
      end
    endcase

    if (do_advance) begin
      if (next_found) begin
        state_d       = RUN;
        idx_d         = next_idx;
        start_d       = next_onehot;
        stage_timer_d = '0;
      end else begin
        state_d = IDLE;
        idx_d   = NO_STAGE;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_q       <= IDLE;
      idx_q         <= NO_STAGE;
      uart_timer_q  <= '0;
      stage_timer_q <= '0;
      start_q       <= '0;
      init_q        <= 1'b0;
      enable_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      uart_timer_q  <= uart_timer_d;
      stage_timer_q <= stage_timer_d;
      start_q       <= start_d;
      init_q        <= init_d;
      enable_q      <= enable_d;
      err_q         <= err_d;
    end
  end

  // SRAM owner mux, driven purely from registered state so an asynchronous
  // reset releases the write enable immediately.
  always_comb begin
    sram_addr_o  = vga_addr_i;
    sram_wdata_o = '0;
    sram_we_n_o  = 1'b1;
    case (state_q)
      UART_RX: begin
        sram_addr_o  = uart_addr_i;
        sram_wdata_o = uart_wdata_i;
        sram_we_n_o  = uart_we_n_i;
      end
      RUN: begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sram_addr_o  = stage_addr_i[k*ADDR_W +: ADDR_W];
            sram_wdata_o = stage_wdata_i[k*DATA_W +: DATA_W];
            sram_we_n_o  = stage_we_n_i[k];
          end
        end
      end
      default: begin
      end
    endcase
  end

  // VGA ownership coincides exactly with the idle state.
  assign vga_enable_o     = (state_q == IDLE);
  assign busy_o           = (state_q != IDLE);
  assign stage_start_o    = start_q;
  assign uart_rx_init_o   = init_q;
  assign uart_rx_enable_o = enable_q;
  assign active_stage_o   = idx_q;
  assign timeout_err_o    = err_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sram_stage_sequencer
//
// Directed self-checking bench for sram_stage_sequencer with three stages, a
// 100-cycle UART timeout and a 50-cycle stage watchdog. Inputs change 1 ns
// after the rising edge and outputs are checked there, away from the edge.
// -----------------------------------------------------------------------------
module tb_sram_stage_sequencer;

  localparam int NS   = 3;
  localparam int AW   = 18;
  localparam int DW   = 16;
  localparam int IW   = $clog2(NS) + 1;

  localparam logic [AW-1:0] S0_ADDR = 18'h00A00;
  localparam logic [AW-1:0] S1_ADDR = 18'h00B11;
  localparam logic [AW-1:0] S2_ADDR = 18'h00C22;
  localparam logic [DW-1:0] S0_DATA = 16'hA0A0;
  localparam logic [DW-1:0] S1_DATA = 16'hB1B1;
  localparam logic [DW-1:0] S2_DATA = 16'hC2C2;
  localparam logic [IW-1:0] NONE    = '1;

  logic              CLOCK_50_I = 1'b0;
  logic              resetn;
  logic              uart_rx_i;
  logic [AW-1:0]     uart_addr_i;
  logic [DW-1:0]     uart_wdata_i;
  logic              uart_we_n_i;
  logic [AW-1:0]     vga_addr_i;
  logic [NS*AW-1:0]  stage_addr_i;
  logic [NS*DW-1:0]  stage_wdata_i;
  logic [NS-1:0]     stage_we_n_i;
  logic [NS-1:0]     stage_stop_i;
  logic [NS-1:0]     stage_enable_i;
  logic [AW-1:0]     sram_addr_o;
  logic [DW-1:0]     sram_wdata_o;
  logic              sram_we_n_o;
  logic [NS-1:0]     stage_start_o;
  logic              uart_rx_init_o;
  logic              uart_rx_enable_o;
  logic              vga_enable_o;
  logic              busy_o;
  logic [IW-1:0]     active_stage_o;
  logic              timeout_err_o;

  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50_I = ~CLOCK_50_I;

  sram_stage_sequencer #(
    .NUM_STAGES   (NS),
    .ADDR_W       (AW),
    .DATA_W       (DW),
    .TIMER_W      (32),
    .UART_TIMEOUT (100),
    .STAGE_TIMEOUT(50)
  ) dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .resetn          (resetn),
    .uart_rx_i       (uart_rx_i),
    .uart_addr_i     (uart_addr_i),
    .uart_wdata_i    (uart_wdata_i),
    .uart_we_n_i     (uart_we_n_i),
    .vga_addr_i      (vga_addr_i),
    .stage_addr_i    (stage_addr_i),
    .stage_wdata_i   (stage_wdata_i),
    .stage_we_n_i    (stage_we_n_i),
    .stage_stop_i    (stage_stop_i),
    .stage_enable_i  (stage_enable_i),
    .sram_addr_o     (sram_addr_o),
    .sram_wdata_o    (sram_wdata_o),
    .sram_we_n_o     (sram_we_n_o),
    .stage_start_o   (stage_start_o),
    .uart_rx_init_o  (uart_rx_init_o),
    .uart_rx_enable_o(uart_rx_enable_o),
    .vga_enable_o    (vga_enable_o),
    .busy_o          (busy_o),
    .active_stage_o  (active_stage_o),
    .timeout_err_o   (timeout_err_o)
  );

  task automatic tick();
    @(posedge CLOCK_50_I);
    #1;
  endtask

  // One-cycle start bit from IDLE; returns 1 ns after the edge that sampled it.
  task automatic start_capture();
    uart_rx_i = 1'b0;
    tick();
    uart_rx_i = 1'b1;
  endtask

  // Edges until a start pulse appears or the sequencer goes idle; -1 if neither.
  task automatic wait_decision(output int n);
    n = -1;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (stage_start_o != '0 || !busy_o) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #25;
    checks++; if (vga_enable_o !== 1'b1) begin errors++; $display("FAIL reset_vga: got %b want 1", vga_enable_o); end
    checks++; if (sram_we_n_o !== 1'b1) begin errors++; $display("FAIL reset_we_n: got %b want 1", sram_we_n_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    checks++; if (sram_addr_o !== 18'h01234) begin errors++; $display("FAIL reset_addr: got %h want 01234", sram_addr_o); end
    checks++; if (sram_wdata_o !== 16'h0000) begin errors++; $display("FAIL reset_wdata: got %h want 0000", sram_wdata_o); end
    checks++; if (active_stage_o !== NONE) begin errors++; $display("FAIL reset_active: got %b want %b", active_stage_o, NONE); end
    checks++; if ({stage_start_o, uart_rx_init_o, uart_rx_enable_o, timeout_err_o} !== 6'b0)
      begin errors++; $display("FAIL reset_pulses: got %b want 000000", {stage_start_o, uart_rx_init_o, uart_rx_enable_o, timeout_err_o}); end
    resetn = 1'b1;
    tick();
    vga_addr_i = 18'h2BEEF;
    #1;
    checks++; if (sram_addr_o !== 18'h2BEEF) begin errors++; $display("FAIL idle_addr_follow: got %h want 2beef", sram_addr_o); end
  endtask

  task automatic test_uart();
    int n;
    stage_enable_i = 3'b001;
    start_capture();
    uart_rx_i = 1'b0;  // held low: must be ignored while busy
    checks++; if ({uart_rx_init_o, uart_rx_enable_o} !== 2'b10) begin errors++; $display("FAIL uart_cycle1: init/en got %b want 10", {uart_rx_init_o, uart_rx_enable_o}); end
    checks++; if ({busy_o, vga_enable_o} !== 2'b10) begin errors++; $display("FAIL uart_owner: busy/vga got %b want 10", {busy_o, vga_enable_o}); end
    tick();
    checks++; if ({uart_rx_init_o, uart_rx_enable_o} !== 2'b01) begin errors++; $display("FAIL uart_cycle2: init/en got %b want 01", {uart_rx_init_o, uart_rx_enable_o}); end
    for (int i = 0; i < 4; i++) begin
      uart_addr_i  = AW'(18'h00100 + i);
      uart_wdata_i = DW'(16'h5A00 + i);
      uart_we_n_i  = 1'b0;
      #1;
      checks++; if ({sram_addr_o, sram_wdata_o, sram_we_n_o} !== {AW'(18'h00100 + i), DW'(16'h5A00 + i), 1'b0})
        begin errors++; $display("FAIL uart_mux%0d: got %h/%h/%b want %h/%h/0", i, sram_addr_o, sram_wdata_o, sram_we_n_o, AW'(18'h00100 + i), DW'(16'h5A00 + i)); end
      tick();
    end
    uart_we_n_i = 1'b1;
    uart_rx_i   = 1'b1;
    checks++; if ({uart_rx_init_o, uart_rx_enable_o} !== 2'b00) begin errors++; $display("FAIL uart_no_repulse: init/en got %b want 00", {uart_rx_init_o, uart_rx_enable_o}); end
    wait_decision(n);
    checks++; if (n !== 100) begin errors++; $display("FAIL uart_timeout_len: got %0d cycles want 100", n); end
    checks++; if (stage_start_o !== 3'b001) begin errors++; $display("FAIL uart_first_start: got %b want 001", stage_start_o); end
    checks++; if (sram_addr_o !== S0_ADDR) begin errors++; $display("FAIL uart_run_addr: got %h want %h", sram_addr_o, S0_ADDR); end
    stage_stop_i = 3'b001;
    tick();
    stage_stop_i = 3'b000;
    checks++; if ({busy_o, vga_enable_o, active_stage_o} !== {2'b01, NONE}) begin errors++; $display("FAIL uart_single_done: busy/vga/idx got %b want 01%b", {busy_o, vga_enable_o, active_stage_o}, NONE); end
  endtask

  task automatic test_skip_and_ignore();
    int n;
    stage_enable_i = 3'b101;
    stage_we_n_i   = 3'b110;
    start_capture();
    wait_decision(n);
    checks++; if (n !== 100) begin errors++; $display("FAIL skip_wait: got %0d cycles want 100", n); end
    checks++; if ({stage_start_o, active_stage_o} !== {3'b001, IW'(0)}) begin errors++; $display("FAIL skip_s0_start: start/idx got %b want 001_000", {stage_start_o, active_stage_o}); end
    stage_stop_i = 3'b010;  // stage 1's stop must not end stage 0
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({stage_start_o, active_stage_o, sram_addr_o, sram_wdata_o, sram_we_n_o} !== {3'b000, IW'(0), S0_ADDR, S0_DATA, 1'b0})
        begin errors++; $display("FAIL ignore_other_stop%0d: start %b idx %0d addr %h data %h we_n %b want 000/0/%h/%h/0", i, stage_start_o, active_stage_o, sram_addr_o, sram_wdata_o, sram_we_n_o, S0_ADDR, S0_DATA); end
    end
    stage_stop_i = 3'b001;
    tick();
    stage_stop_i = 3'b100;  // stage 2 stops in its start cycle
    checks++; if ({stage_start_o, active_stage_o} !== {3'b100, IW'(2)}) begin errors++; $display("FAIL skip_s2_start: start/idx got %b want 100_010", {stage_start_o, active_stage_o}); end
    checks++; if ({sram_addr_o, sram_wdata_o, sram_we_n_o} !== {S2_ADDR, S2_DATA, 1'b1}) begin errors++; $display("FAIL skip_s2_mux: got %h/%h/%b want %h/%h/1", sram_addr_o, sram_wdata_o, sram_we_n_o, S2_ADDR, S2_DATA); end
    tick();
    stage_stop_i = 3'b000;
    checks++; if ({busy_o, vga_enable_o, stage_start_o, active_stage_o} !== {2'b01, 3'b000, NONE}) begin errors++; $display("FAIL skip_end_idle: busy/vga/start/idx got %b want 01000%b", {busy_o, vga_enable_o, stage_start_o, active_stage_o}, NONE); end
    checks++; if ({sram_addr_o, sram_we_n_o} !== {vga_addr_i, 1'b1}) begin errors++; $display("FAIL skip_end_mux: got %h/%b want %h/1", sram_addr_o, sram_we_n_o, vga_addr_i); end
  endtask

  task automatic test_watchdog();
    int n;
    bit seen1;
    stage_enable_i = 3'b011;
    start_capture();
    wait_decision(n);
    checks++; if (stage_start_o !== 3'b001) begin errors++; $display("FAIL wdog_start: got %b want 001", stage_start_o); end
    n = -1;
    seen1 = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (stage_start_o[1]) seen1 = 1'b1;
      if (!busy_o) begin
        n = i;
        break;
      end
    end
    checks++; if (n !== 50) begin errors++; $display("FAIL wdog_len: got %0d cycles want 50", n); end
    checks++; if (seen1 !== 1'b0) begin errors++; $display("FAIL wdog_no_s1: stage 1 start seen %b want 0", seen1); end
    checks++; if ({timeout_err_o, vga_enable_o, active_stage_o} !== {2'b11, NONE}) begin errors++; $display("FAIL wdog_flags: err/vga/idx got %b want 11%b", {timeout_err_o, vga_enable_o, active_stage_o}, NONE); end
    tick();
    checks++; if (timeout_err_o !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b want 1", timeout_err_o); end
  endtask

  task automatic test_enable_zero();
    int n;
    stage_enable_i = 3'b000;
    start_capture();
    checks++; if (timeout_err_o !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b want 0", timeout_err_o); end
    wait_decision(n);
    checks++; if (n !== 100) begin errors++; $display("FAIL none_enabled_len: got %0d cycles want 100", n); end
    checks++; if ({stage_start_o, busy_o, vga_enable_o} !== 5'b00001) begin errors++; $display("FAIL none_enabled_idle: start/busy/vga got %b want 00001", {stage_start_o, busy_o, vga_enable_o}); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    stage_enable_i = 3'b001;
    stage_we_n_i   = 3'b110;
    start_capture();
    wait_decision(n);
    tick();
    checks++; if ({busy_o, sram_we_n_o} !== 2'b10) begin errors++; $display("FAIL midrun_pre: busy/we_n got %b want 10", {busy_o, sram_we_n_o}); end
    #5 resetn = 1'b0;
    #1;
    checks++; if ({busy_o, sram_we_n_o, vga_enable_o} !== 3'b011) begin errors++; $display("FAIL midrun_reset: busy/we_n/vga got %b want 011", {busy_o, sram_we_n_o, vga_enable_o}); end
    checks++; if ({active_stage_o, sram_addr_o} !== {NONE, vga_addr_i}) begin errors++; $display("FAIL midrun_reset_idx: idx/addr got %b/%h want %b/%h", active_stage_o, sram_addr_o, NONE, vga_addr_i); end
    #4 resetn = 1'b1;
    tick();
    checks++; if ({busy_o, stage_start_o, timeout_err_o} !== 5'b0) begin errors++; $display("FAIL midrun_after: busy/start/err got %b want 00000", {busy_o, stage_start_o, timeout_err_o}); end
  endtask

  initial begin
    uart_rx_i      = 1'b1;
    uart_addr_i    = '0;
    uart_wdata_i   = '0;
    uart_we_n_i    = 1'b1;
    vga_addr_i     = 18'h01234;
    stage_addr_i   = {S2_ADDR, S1_ADDR, S0_ADDR};
    stage_wdata_i  = {S2_DATA, S1_DATA, S0_DATA};
    stage_we_n_i   = 3'b111;
    stage_stop_i   = 3'b000;
    stage_enable_i = 3'b000;
    resetn         = 1'b0;

    test_reset();
    test_uart();
    test_skip_and_ignore();
    test_watchdog();
    test_enable_zero();
    test_reset_mid_run();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
